// File: rtl/branch_issue_queue_pkg.sv
// Shared definitions for the branch issue queue: scoreboard id width,
// branch func codes, datapath widths and the per-entry metadata payload.
// SCOREBOARD_SIZE_WIDTH normally comes from the core-wide defines; the
// fallback below only applies when this slice is built on its own.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package branch_issue_queue_pkg;

    localparam int unsigned SID_W  = `SCOREBOARD_SIZE_WIDTH + 1;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned FC_W   = 4;

    localparam logic [FC_W-1:0] FC_JAL  = 4'b0111;
    localparam logic [FC_W-1:0] FC_JALR = 4'b0101;
    localparam logic [FC_W-1:0] FC_BR   = 4'b0100;

    // Non-operand fields of one queue entry
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [SID_W-1:0]  sid;
        logic [FC_W-1:0]   func_code;
    } entry_meta_t;

endpackage

// File: rtl/branch_iq_operand.sv
// One source-operand slot of a branch issue queue entry.
// Captures ready/value/sid at enqueue (with same-cycle wakeup bypass) and
// latches a writeback value when a broadcast matches its pending sid.
// Ports: clk, rst_n; entry_valid (owning entry occupied); enq + enq_ready/
// enq_value/enq_sid (dispatch write); wb_valid/wb_sid/wb_value (wakeup bus);
// ready/value (registered slot state).
module branch_iq_operand
    import branch_issue_queue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_valid,
    input  logic             enq,
    input  logic             enq_ready,
    input  logic [XLEN-1:0]  enq_value,
    input  logic [SID_W-1:0] enq_sid,
    input  logic             wb_valid,
    input  logic [SID_W-1:0] wb_sid,
    input  logic [XLEN-1:0]  wb_value,
    output logic             ready,
    output logic [XLEN-1:0]  value
);

    logic [SID_W-1:0] sid;
    logic             enq_hit;
    logic             wake_hit;

    // Producer writing back in the dispatch cycle itself
    assign enq_hit  = !enq_ready && wb_valid && (wb_sid == enq_sid);
    // Pending operand of an occupied entry matching the broadcast
    assign wake_hit = entry_valid && !ready && wb_valid && (wb_sid == sid);

    // Slot state: enqueue write has priority over wakeup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
            value <= '0;
            sid   <= '0;
        end else if (enq) begin
            ready <= enq_ready || enq_hit;
            value <= enq_hit ? wb_value : enq_value;
            sid   <= enq_sid;
        end else if (wake_hit) begin
            ready <= 1'b1;
            value <= wb_value;
        end
    end

endmodule

// File: rtl/branch_issue_queue.sv
// In-order issue buffer feeding the branch execution unit. Holds dispatched
// branch/jump micro-ops until both operands are ready, then issues the head
// entry (at most one per cycle) in program order.
// Ports: clk, rst_n, flush_i; dispatch disp_* (valid/ready handshake, pc,
// inst, sid, func code, per-operand ready/value/sid); writeback wb_valid_i/
// wb_sid_i/wb_value_i; BEU issue branch_valid_o, branch_pc_o, branch_inst_o,
// branch_sid_o, rs1_value_o, rs2_value_o, func_code_o.
// Optional macro BRANCH_IQ_STALL_CNT_EN adds stall_cnt_o, a saturating count
// of cycles the head is valid but waiting on an operand (cleared only by reset).
module branch_issue_queue
    import branch_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              disp_valid_i,
    output logic              disp_ready_o,
    input  logic [XLEN-1:0]   disp_pc_i,
    input  logic [INST_W-1:0] disp_inst_i,
    input  logic [SID_W-1:0]  disp_sid_i,
    input  logic [FC_W-1:0]   disp_func_code_i,
    input  logic              disp_rs1_ready_i,
    input  logic              disp_rs2_ready_i,
    input  logic [XLEN-1:0]   disp_rs1_value_i,
    input  logic [XLEN-1:0]   disp_rs2_value_i,
    input  logic [SID_W-1:0]  disp_rs1_sid_i,
    input  logic [SID_W-1:0]  disp_rs2_sid_i,
    input  logic              wb_valid_i,
    input  logic [SID_W-1:0]  wb_sid_i,
    input  logic [XLEN-1:0]   wb_value_i,
    output logic              branch_valid_o,
    output logic [XLEN-1:0]   branch_pc_o,
    output logic [INST_W-1:0] branch_inst_o,
    output logic [SID_W-1:0]  branch_sid_o,
    output logic [XLEN-1:0]   rs1_value_o,
    output logic [XLEN-1:0]   rs2_value_o,
    output logic [FC_W-1:0]   func_code_o
`ifdef BRANCH_IQ_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    entry_meta_t      meta_q [DEPTH];

    logic [DEPTH-1:0] rs1_rdy;
    logic [DEPTH-1:0] rs2_rdy;
    logic [XLEN-1:0]  rs1_val [DEPTH];
    logic [XLEN-1:0]  rs2_val [DEPTH];

    logic enq;
    logic issue;

    // Handshake and issue qualification from registered state
    assign disp_ready_o   = (count != (PTR_W+1)'(DEPTH));
    assign enq            = disp_valid_i && disp_ready_o && !flush_i;
    assign issue          = valid_q[head] && rs1_rdy[head] && rs2_rdy[head] && !flush_i;
    assign branch_valid_o = issue;

    // Issue payload straight from the head entry (stale when empty)
    assign branch_pc_o   = meta_q[head].pc;
    assign branch_inst_o = meta_q[head].inst;
    assign branch_sid_o  = meta_q[head].sid;
    assign func_code_o   = meta_q[head].func_code;
    assign rs1_value_o   = rs1_val[head];
    assign rs2_value_o   = rs2_val[head];

    // Entry occupancy next state; enqueue and issue never hit the same slot
    always_comb begin
        valid_d = valid_q;
        if (enq)     valid_d[tail] = 1'b1;
        if (issue)   valid_d[head] = 1'b0;
        if (flush_i) valid_d = '0;
    end

    // Pointers, count and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (flush_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq)   tail <= tail + PTR_W'(1);
                if (issue) head <= head + PTR_W'(1);
                case ({enq, issue})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry metadata written at the tail on enqueue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) meta_q[i] <= '0;
        end else if (enq) begin
            meta_q[tail] <= '{pc: disp_pc_i, inst: disp_inst_i,
                              sid: disp_sid_i, func_code: disp_func_code_i};
        end
    end

    // Two operand slots per entry
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic enq_slot;
        assign enq_slot = enq && (tail == PTR_W'(i));

        branch_iq_operand u_rs1 (
            .clk         (clk),
            .rst_n       (rst_n),
            .entry_valid (valid_q[i]),
            .enq         (enq_slot),
            .enq_ready   (disp_rs1_ready_i),
            .enq_value   (disp_rs1_value_i),
            .enq_sid     (disp_rs1_sid_i),
            .wb_valid    (wb_valid_i),
            .wb_sid      (wb_sid_i),
            .wb_value    (wb_value_i),
            .ready       (rs1_rdy[i]),
            .value       (rs1_val[i])
        );

        branch_iq_operand u_rs2 (
            .clk         (clk),
            .rst_n       (rst_n),
            .entry_valid (valid_q[i]),
            .enq         (enq_slot),
            .enq_ready   (disp_rs2_ready_i),
            .enq_value   (disp_rs2_value_i),
            .enq_sid     (disp_rs2_sid_i),
            .wb_valid    (wb_valid_i),
            .wb_sid      (wb_sid_i),
            .wb_value    (wb_value_i),
            .ready       (rs2_rdy[i]),
            .value       (rs2_val[i])
        );
    end

`ifdef BRANCH_IQ_STALL_CNT_EN
    logic head_stalled;
    assign head_stalled = valid_q[head] && !(rs1_rdy[head] && rs2_rdy[head]);

    // Saturating head-stall counter; survives flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (head_stalled && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/branch_issue_queue.md
Name: branch_issue_queue

Overview:
- In-order issue buffer directly upstream of the branch execution unit.
- Accepts branch/jump micro-ops from dispatch and holds each one until both source operands are available.
- Operands are captured either at dispatch or from the writeback wakeup bus.
- Issues the head entry, one per cycle, in program order, onto the BEU input interface (valid, pc, inst, sid, rs1/rs2 values, func code).

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, at least 2.
- PTR_W, 2, log2(DEPTH); used for the head/tail pointers.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush (redirect or exception); empties the queue
- disp_valid_i  in  1  dispatch offers a branch micro-op
- disp_ready_o  out  1  queue can accept this cycle
- disp_pc_i  in  64  instruction PC
- disp_inst_i  in  32  raw instruction
- disp_sid_i  in  `SCOREBOARD_SIZE_WIDTH+1  scoreboard id of the branch
- disp_func_code_i  in  4  0111 jal, 0101 jalr, 0100 conditional branch
- disp_rs1_ready_i / disp_rs2_ready_i  in  1  operand value already valid
- disp_rs1_value_i / disp_rs2_value_i  in  64  operand value, meaningful when the matching ready is high
- disp_rs1_sid_i / disp_rs2_sid_i  in  `SCOREBOARD_SIZE_WIDTH+1  producer sid, meaningful when the matching ready is low
- wb_valid_i  in  1  writeback broadcast valid
- wb_sid_i  in  `SCOREBOARD_SIZE_WIDTH+1  producer sid of the writeback
- wb_value_i  in  64  writeback value
- branch_valid_o  out  1  issue to BEU
- branch_pc_o  out  64  PC of issued entry
- branch_inst_o  out  32  instruction of issued entry
- branch_sid_o  out  `SCOREBOARD_SIZE_WIDTH+1  sid of issued entry
- rs1_value_o / rs2_value_o  out  64  operand values of issued entry
- func_code_o  out  4  func code of issued entry

Behaviour:
- Reset:
  - head, tail and count are 0; all entry valid bits are 0.
  - disp_ready_o = 1; branch_valid_o = 0.
  - All data outputs read 0 during reset.
- Circular buffer:
  - Enqueue writes at tail; issue reads from head.
  - Both pointers wrap modulo DEPTH.
  - count is PTR_W+1 bits wide.
- Enqueue and ready:
  - Enqueue occurs when disp_valid_i & disp_ready_o & !flush_i.
  - disp_ready_o = (count != DEPTH), taken from the registered count only. A full queue does not accept in a cycle where it also issues.
- Operand capture at enqueue:
  - Each operand stores ready, value and sid.
  - If the operand is not ready but a wakeup matches its sid in the same cycle (wb_valid_i & wb_sid_i == disp_rsX_sid_i), the operand is written as ready with wb_value_i.
- Wakeup:
  - Every cycle, each valid entry's not-ready operand whose sid equals wb_sid_i (with wb_valid_i high) sets ready and latches wb_value_i.
  - Multiple entries or operands may wake on one broadcast.
  - Invalid entries and already-ready operands are unaffected.
- Issue:
  - branch_valid_o = head valid & rs1 ready & rs2 ready & !flush_i.
  - The data outputs are driven combinationally from the head entry registers.
  - The BEU always accepts; there is no back-pressure.
  - When branch_valid_o is high, head advances, count decrements and the head valid bit clears at the clock edge.
- Ordering and latency:
  - Strictly in order: a not-ready head blocks younger ready entries.
  - An entry is issuable no earlier than the cycle after it is enqueued.
  - Minimum latency from dispatch to BEU input is 1 cycle.
- Simultaneous enqueue and issue: count is unchanged; both pointers advance.
- Flush:
  - Synchronous priority over all other updates: head = tail = count = 0 and all valid bits clear.
  - Same-cycle enqueue is dropped and same-cycle issue is suppressed.
  - disp_ready_o in the following cycle is 1.
- Empty queue: branch_valid_o = 0 and data outputs hold the stale head contents.
- Reset mid-operation: asynchronously returns to the reset state regardless of contents.

Optional Feature:
- Macro: BRANCH_IQ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o (32 bits).
  - The counter increments each cycle the head is valid but not issued (operand not ready), and saturates at 0xFFFFFFFF.
  - It is cleared only by reset; flush does not clear it.
- When undefined: the port and the counter logic are absent.

Decomposition:
- Shared package/include:
  - `SCOREBOARD_SIZE_WIDTH, which already exists.
  - Func code constants FC_JAL=4'b0111, FC_JALR=4'b0101, FC_BR=4'b0100.
  - Entry field widths.
- Sub-module: branch_iq_operand, a single operand slot holding ready/value/sid with enqueue capture and wakeup match. It is instantiated 2*DEPTH times.
- Pointer, count and issue logic stay in the top module.

Test Plan:
- Reset, then enqueue jal pc=0x1000 sid=3 with both operands ready -> branch_valid_o=1 the next cycle with pc 0x1000, sid 3, func 0111; queue empty afterwards.
- Enqueue beq with rs1 not ready (sid 5), then wb_valid_i with sid 5 and value 0x2A two cycles later -> issue occurs the cycle after the wakeup with rs1_value_o=0x2A.
- Enqueue an entry whose operand is not ready in the same cycle that wb matches its sid -> value captured; issue the next cycle.
- Head blocked on an operand while entry 2 is ready -> no issue until the head wakes; then issues are head then entry 2 on consecutive cycles.
- Fill 4 entries -> disp_ready_o=0; offered enqueue dropped; one issue -> disp_ready_o=1; tail wraps to 0 on the next enqueue.
- flush_i asserted with 3 entries plus a concurrent enqueue and a ready head -> branch_valid_o=0 that cycle; count=0 and disp_ready_o=1 the next cycle.
